// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path.
// Contents:
//   state_e           - handshake/conversion FSM states (IDLE, CONV, LOAD)
//   SEG_BLANK         - all segments off, active-high form
//   SEG_DASH          - segment g only, active-high form
//   seven_seg_decode  - hex nibble to active-high {a,b,c,d,e,f,g}
//   seg_polarity      - converts an active-high pattern to the pin polarity
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h01;

  // Bit 6 is segment a, bit 0 is segment g; a set bit means the segment is lit.
  function automatic logic [6:0] seven_seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_i     - loads bin_i and begins a conversion (one shift per cycle)
//   bin_i       - binary value to convert
//   done_o      - high during the cycle in which the final shift happens
//   bcd_o       - NUM_DIGITS packed BCD digits, valid after done_o
//   ovf_o       - sticky: a 1 was shifted out of the top BCD digit
module bin2bcd_serial #(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    ovf_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              ovf_q;

  // Add-3 correction so that each digit carries correctly on the next shift.
  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (start_i) begin
      shift_q <= bin_i;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else if (busy_q) begin
      bcd_q   <= {adj_d[BCD_W-2:0], shift_q[DATA_W-1]};
      shift_q <= shift_q << 1;
      cnt_q   <= cnt_q + 1'b1;
      // Digits above the top one are not stored; losing a 1 means the value did not fit.
      if (adj_d[BCD_W-1]) begin
        ovf_q <= 1'b1;
      end
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bcd_o = bcd_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/seg_mux_driver.sv
// Multiplexed N-digit seven-segment driver with hex/BCD display,
// brightness PWM, leading-zero blanking, overflow dashes and decimal points.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   val_valid/val_ready   - value handshake; val_data and hex_mode sampled on transfer
//   lz_blank, dp_in       - live display options
//   brightness            - 0 (dark) .. 15 (15/16 duty), applied at slot boundaries
//   seg, seg_dp, dig_sel  - registered pin drivers
//   ovf                   - shown value did not fit in NUM_DIGITS digits
module seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DATA_W         = 14,
  parameter int CLK_IN_HZ      = 84_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  val_valid,
  output logic                  val_ready,
  input  logic [DATA_W-1:0]     val_data,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  ovf
);

  localparam int BCD_W    = 4 * NUM_DIGITS;
  localparam int DWELL    = CLK_IN_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int SLOT_LEN = (DWELL >= 16) ? DWELL / 16 : 1;
  localparam int SLOT_W   = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            SEG_OFF = seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW);
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  // Handshake / display register state
  state_e              state_q;
  logic                ready_q;
  logic [DATA_W-1:0]   data_q;
  logic                hex_q;
  logic [BCD_W-1:0]    digits_q;
  logic                ovf_q;

  // Scan state
  logic [SLOT_W-1:0]   tick_q;
  logic [3:0]          slot_q;
  logic [IDX_W-1:0]    idx_q;
  logic [3:0]          bright_q;

  // Pin registers
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic                     conv_start;
  logic                     conv_done;
  logic [BCD_W-1:0]         conv_bcd;
  logic                     conv_ovf;
  logic [DATA_W+BCD_W-1:0]  hex_ext;

  assign conv_start = (state_q == IDLE) && ready_q && val_valid && !hex_mode;

  bin2bcd_serial #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .bin_i   (val_data),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  // Zero-extension lets narrow and wide DATA_W share one expression for
  // the low nibbles and the "bits above the display" overflow test.
  assign hex_ext = {{BCD_W{1'b0}}, data_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      data_q   <= '0;
      hex_q    <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (val_valid && ready_q) begin
            data_q  <= val_data;
            hex_q   <= hex_mode;
            ready_q <= 1'b0;
            state_q <= hex_mode ? LOAD : CONV;
          end
        end
        CONV: begin
          if (conv_done) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (hex_q) begin
            digits_q <= hex_ext[BCD_W-1:0];
            ovf_q    <= |(hex_ext >> BCD_W);
          end else begin
            digits_q <= conv_bcd;
            ovf_q    <= conv_ovf;
          end
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Brightness is captured only when a new slot starts so a mid-slot change
  // never produces a partial slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= '0;
      slot_q   <= '0;
      idx_q    <= '0;
      bright_q <= '0;
    end else if (tick_q == SLOT_W'(SLOT_LEN - 1)) begin
      tick_q   <= '0;
      slot_q   <= slot_q + 4'd1;
      bright_q <= brightness;
      if (slot_q == 4'd15) begin
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  // bright_q never exceeds 15, so slot 15 is always outside the window.
  always_comb begin
    logic [3:0]       nib;
    logic [BCD_W-1:0] upper;
    logic             blank;
    logic [6:0]       raw;
    nib   = digits_q[{idx_q, 2'b00} +: 4];
    upper = digits_q >> {idx_q, 2'b00};
    blank = lz_blank && (idx_q != '0) && (upper == '0);
    if (ovf_q) begin
      raw = SEG_DASH;
    end else if (blank) begin
      raw = SEG_BLANK;
    end else begin
      raw = seven_seg_decode(nib);
    end
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    sel_d = SEL_OFF;
    if (slot_q < bright_q) begin
      seg_d = seg_polarity(raw, SEG_ACTIVE_LOW);
      dp_d  = dp_in[idx_q] ^ SEG_ACTIVE_LOW;
      sel_d = (NUM_DIGITS'(1) << idx_q) ^ SEL_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      sel_q <= SEL_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      sel_q <= sel_d;
    end
  end

  assign val_ready = ready_q;
  assign ovf       = ovf_q;
  assign seg       = seg_q;
  assign seg_dp    = dp_q;
  assign dig_sel   = sel_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Self-checking bench for seg_mux_driver with a 16-cycle dwell (1-cycle slots).
// The reference model derives each digit arithmetically from the accepted
// value (division / modulo by powers of 10 or 16) and checks every sampled
// cycle of a full frame against it.
module tb_seg_mux_driver;

  localparam int ND = 4;
  localparam int DW = 14;
  localparam int FRAME = 64;

  logic          clk;
  logic          rst_n;
  logic          val_valid;
  logic          val_ready;
  logic [DW-1:0] val_data;
  logic          hex_mode;
  logic          lz_blank;
  logic [ND-1:0] dp_in;
  logic [3:0]    brightness;
  logic [6:0]    seg;
  logic          seg_dp;
  logic [ND-1:0] dig_sel;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: last accepted value and mode
  int m_val = 0;
  bit m_hex = 1'b0;

  seg_mux_driver #(
    .NUM_DIGITS     (ND),
    .DATA_W         (DW),
    .CLK_IN_HZ      (1600),
    .SCAN_HZ        (25),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .val_data   (val_data),
    .hex_mode   (hex_mode),
    .lz_blank   (lz_blank),
    .dp_in      (dp_in),
    .brightness (brightness),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .dig_sel    (dig_sel),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Active-low segment patterns for glyphs 0-F as drawn on the board.
  function automatic logic [6:0] font_lo(input int d);
    case (d)
      0: return 7'h01;   1: return 7'h4F;   2: return 7'h12;   3: return 7'h06;
      4: return 7'h4C;   5: return 7'h24;   6: return 7'h20;   7: return 7'h0F;
      8: return 7'h00;   9: return 7'h04;  10: return 7'h08;  11: return 7'h60;
      12: return 7'h31; 13: return 7'h42;  14: return 7'h30;  default: return 7'h38;
    endcase
  endfunction

  function automatic bit exp_ovf();
    return m_hex ? (m_val >= 65536) : (m_val >= 10000);
  endfunction

  function automatic logic [6:0] exp_seg(input int pos);
    int base, scale, shown;
    base  = m_hex ? 16 : 10;
    scale = 1;
    for (int k = 0; k < pos; k++) scale = scale * base;
    shown = m_hex ? (m_val % 65536) : (m_val % 10000);
    if (exp_ovf()) return 7'h7E;
    if (lz_blank && pos != 0 && shown < scale) return 7'h7F;
    return font_lo((shown / scale) % base);
  endfunction

  // Samples a window of whole frames: every cycle must be either fully dark or
  // one digit showing the model's glyph, and each digit must be lit exactly
  // 'brightness' cycles per frame.
  task automatic check_frame(input string tag, input int ncyc);
    int cnt [ND];
    int idx;
    for (int i = 0; i < ND; i++) cnt[i] = 0;
    repeat (ncyc) begin
      @(negedge clk);
      checks++;
      if (dig_sel === '0) begin
        if (seg !== 7'h7F || seg_dp !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s dark: seg=%h dp=%b, required seg=7f dp=1", tag, seg, seg_dp);
        end
      end else begin
        idx = -1;
        for (int i = 0; i < ND; i++) if (dig_sel === (ND'(1) << i)) idx = i;
        if (idx < 0) begin
          errors++;
          $display("[TB] FAIL %s onehot: dig_sel=%b, required one-hot or zero", tag, dig_sel);
        end else begin
          cnt[idx]++;
          if (seg !== exp_seg(idx) || seg_dp !== ~dp_in[idx]) begin
            errors++;
            $display("[TB] FAIL %s digit%0d: seg=%h dp=%b, required seg=%h dp=%b",
                     tag, idx, seg, seg_dp, exp_seg(idx), ~dp_in[idx]);
          end
        end
      end
    end
    checks++;
    if (ovf !== exp_ovf()) begin
      errors++;
      $display("[TB] FAIL %s ovf: got %b, required %b", tag, ovf, exp_ovf());
    end
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (cnt[i] != int'(brightness) * (ncyc / FRAME)) begin
        errors++;
        $display("[TB] FAIL %s duty digit%0d: lit %0d cycles, required %0d",
                 tag, i, cnt[i], int'(brightness) * (ncyc / FRAME));
      end
    end
  endtask

  // Offers one value, counts the not-ready cycles and checks the old value
  // stays up meanwhile; 'poke' also offers a bogus value while busy.
  task automatic send(input int value, input bit hx, input bit poke);
    int n;
    n = 0;
    @(negedge clk);
    while (val_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (val_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_wait: val_ready=%b, required 1", val_ready);
    end
    val_data  = DW'(value);
    hex_mode  = hx;
    val_valid = 1'b1;
    @(posedge clk);
    #1;
    val_valid = 1'b0;
    val_data  = DW'($urandom);
    hex_mode  = ~hx;
    n = 0;
    forever begin
      @(negedge clk);
      if (val_ready === 1'b1 || n >= 100) break;
      n++;
      checks++;
      if (ovf !== exp_ovf()) begin
        errors++;
        $display("[TB] FAIL hold_ovf: ovf=%b during update, required %b", ovf, exp_ovf());
      end
      if (poke && n == 3) begin
        val_valid = 1'b1;
        val_data  = DW'(9999);
        hex_mode  = 1'b1;
      end
      if (poke && n == 6) val_valid = 1'b0;
    end
    checks++;
    if (n != (hx ? 1 : DW + 1)) begin
      errors++;
      $display("[TB] FAIL ready_low: %0d cycles, required %0d", n, hx ? 1 : DW + 1);
    end
    m_val = value;
    m_hex = hx;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (seg !== 7'h7F || seg_dp !== 1'b1 || dig_sel !== 4'b0000 || val_ready !== 1'b1 || ovf !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset: seg=%h dp=%b sel=%b rdy=%b ovf=%b, required 7f 1 0000 1 0",
                 seg, seg_dp, dig_sel, val_ready, ovf);
      end
    end
    rst_n = 1'b1;
    m_val = 0;
    m_hex = 1'b0;
    check_frame("post_reset_dark", FRAME);
  endtask

  task automatic test_bcd_1234();
    brightness = 4'd15;
    lz_blank   = 1'b0;
    dp_in      = '0;
    send(1234, 1'b0, 1'b1);
    check_frame("bcd1234", FRAME);
  endtask

  task automatic test_hex_02a5();
    lz_blank = 1'b1;
    dp_in    = 4'b0100;
    send('h02A5, 1'b1, 1'b0);
    check_frame("hex02a5", FRAME);
  endtask

  task automatic test_overflow();
    lz_blank = 1'b0;
    dp_in    = 4'b1001;
    send(12345, 1'b0, 1'b0);
    check_frame("ovf12345", FRAME);
    lz_blank = 1'b1;
    dp_in    = '0;
    send(42, 1'b0, 1'b0);
    check_frame("bcd0042", FRAME);
  endtask

  task automatic test_brightness();
    brightness = 4'd4;
    repeat (3) @(negedge clk);
    check_frame("bright4", FRAME);
    brightness = 4'd0;
    repeat (3) @(negedge clk);
    check_frame("bright0", 2 * FRAME);
  endtask

  task automatic test_reset_mid_conv();
    brightness = 4'd15;
    lz_blank   = 1'b0;
    @(negedge clk);
    val_data  = DW'(9999);
    hex_mode  = 1'b0;
    val_valid = 1'b1;
    @(posedge clk);
    #1;
    val_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'h7F || seg_dp !== 1'b1 || dig_sel !== 4'b0000 || val_ready !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reset: seg=%h dp=%b sel=%b rdy=%b ovf=%b, required 7f 1 0000 1 0",
               seg, seg_dp, dig_sel, val_ready, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_val = 0;
    m_hex = 1'b0;
    repeat (3) @(negedge clk);
    check_frame("after_abort", FRAME);
    send(7, 1'b0, 1'b0);
    check_frame("bcd0007", FRAME);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      lz_blank   = 1'($urandom_range(0, 1));
      dp_in      = ND'($urandom);
      brightness = 4'($urandom_range(0, 15));
      send(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_frame("random", FRAME);
    end
  endtask

  task automatic test_back_to_back();
    brightness = 4'd9;
    lz_blank   = 1'b1;
    send(5, 1'b1, 1'b0);
    send(600, 1'b0, 1'b0);
    send('h3FFF, 1'b1, 1'b0);
    check_frame("b2b", FRAME);
  endtask

  initial begin
    rst_n      = 1'b0;
    val_valid  = 1'b0;
    val_data   = '0;
    hex_mode   = 1'b0;
    lz_blank   = 1'b0;
    dp_in      = '0;
    brightness = 4'd0;
    test_reset();
    test_bcd_1234();
    test_hex_02a5();
    test_overflow();
    test_brightness();
    test_reset_mid_conv();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
